// File: rtl/reg_file_wb.sv
// Register file with write-back port, two registered read ports with write-first
// bypass, and a per-register pending scoreboard for decode hazard detection.
module reg_file_wb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              hold,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              busy_a,
  output logic              busy_b
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  pending;
  logic [NREGS-1:0]  pending_nxt;

  logic              wb_live;
  logic              issue_live;
  logic              byp_a;
  logic              byp_b;
  logic [DATA_W-1:0] rd_nxt_a;
  logic [DATA_W-1:0] rd_nxt_b;

  // Register 0 is hard-wired to zero, so writes and issues to it are dropped here.
  assign wb_live    = wb_en && (wb_addr != '0);
  assign issue_live = issue_en && (issue_addr != '0);

  assign byp_a = wb_live && (wb_addr == rd_addr_a);
  assign byp_b = wb_live && (wb_addr == rd_addr_b);

  // Write-first: a same-cycle write-back to the source is forwarded to the read latch.
  always_comb begin
    rd_nxt_a = regs[rd_addr_a];
    rd_nxt_b = regs[rd_addr_b];
    if (byp_a) rd_nxt_a = wb_data;
    if (byp_b) rd_nxt_b = wb_data;
  end

  // Clear on write-back first, then set on issue so a same-cycle issue wins.
  always_comb begin
    pending_nxt = pending;
    if (wb_live)    pending_nxt[wb_addr]    = 1'b0;
    if (issue_live) pending_nxt[issue_addr] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_live) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  // Decode stall freezes only the read latches; writes and scoreboard keep going.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else if (!hold) begin
      rd_data_a <= rd_nxt_a;
      rd_data_b <= rd_nxt_b;
    end
  end

  // A write-back landing this cycle resolves the hazard without waiting for the edge.
  assign busy_a = pending[rd_addr_a] && !(wb_en && (wb_addr == rd_addr_a));
  assign busy_b = pending[rd_addr_b] && !(wb_en && (wb_addr == rd_addr_b));

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed self-checking bench for reg_file_wb.
module tb_reg_file_wb;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  logic              clk;
  logic              rst_n;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic              hold;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              busy_a;
  logic              busy_b;

  int n_cmp = 0;
  int n_err = 0;

  reg_file_wb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .hold       (hold),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .busy_a     (busy_a),
    .busy_b     (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                          input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    rd_addr_a = '0; rd_addr_b = '0; hold = 1'b0; issue_en = 1'b0; issue_addr = '0;
    #3;
    check_eq("reset_rd_a", rd_data_a, 32'h0);
    check_eq("reset_rd_b", rd_data_b, 32'h0);

    // Activity while held in reset must be ignored
    wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'hCAFE_F00D;
    issue_en = 1'b1; issue_addr = 5'd4; rd_addr_a = 5'd4;
    tick(); tick();
    check_eq("reset_busy_a", 32'(busy_a), 32'h0);
    check_eq("reset_rd_a_held", rd_data_a, 32'h0);
    wb_en = 1'b0; issue_en = 1'b0;
    rst_n = 1'b1;
    tick();
    check_eq("post_reset_reg4", rd_data_a, 32'h0);
    check_eq("post_reset_busy4", 32'(busy_a), 32'h0);

    // Write then read one cycle later
    write_reg(5'd5, 32'hDEAD_BEEF);
    rd_addr_a = 5'd5;
    tick();
    check_eq("read_reg5", rd_data_a, 32'hDEAD_BEEF);

    // Write-first bypass on port B
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h1234_5678; rd_addr_b = 5'd7;
    tick();
    wb_en = 1'b0;
    check_eq("bypass_b", rd_data_b, 32'h1234_5678);

    // Register 0 ignores writes and issues
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    issue_en = 1'b1; issue_addr = 5'd0; rd_addr_a = 5'd0;
    #1;
    check_eq("r0_busy_comb", 32'(busy_a), 32'h0);
    tick();
    wb_en = 1'b0; issue_en = 1'b0;
    #1;
    check_eq("r0_busy_after", 32'(busy_a), 32'h0);
    check_eq("r0_read_bypass", rd_data_a, 32'h0);
    tick();
    check_eq("r0_read", rd_data_a, 32'h0);

    // Both ports on the same register
    rd_addr_a = 5'd5; rd_addr_b = 5'd5;
    tick();
    check_eq("same_reg_a", rd_data_a, 32'hDEAD_BEEF);
    check_eq("same_reg_b", rd_data_b, 32'hDEAD_BEEF);

    // Scoreboard set, busy, same-cycle clear
    issue_en = 1'b1; issue_addr = 5'd3;
    tick();
    issue_en = 1'b0; rd_addr_a = 5'd3; rd_addr_b = 5'd3;
    #1;
    check_eq("busy_a_set", 32'(busy_a), 32'h1);
    check_eq("busy_b_set", 32'(busy_b), 32'h1);
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_0033;
    #1;
    check_eq("busy_a_wb_comb", 32'(busy_a), 32'h0);
    tick();
    wb_en = 1'b0;
    #1;
    check_eq("busy_a_cleared", 32'(busy_a), 32'h0);
    check_eq("reg3_bypass", rd_data_a, 32'h0000_0033);

    // Simultaneous issue and write-back: set wins, data written
    issue_en = 1'b1; issue_addr = 5'd6;
    wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h0000_0066;
    tick();
    issue_en = 1'b0; wb_en = 1'b0; rd_addr_a = 5'd6;
    #1;
    check_eq("set_wins_busy", 32'(busy_a), 32'h1);
    tick();
    check_eq("set_wins_data", rd_data_a, 32'h0000_0066);
    write_reg(5'd6, 32'h0000_0067);
    check_eq("reg6_cleared", 32'(busy_a), 32'h0);

    // Hold freezes read latches but not writes or scoreboard
    write_reg(5'd1, 32'h0000_0011);
    write_reg(5'd2, 32'h0000_0022);
    rd_addr_a = 5'd1;
    tick();
    check_eq("hold_pre", rd_data_a, 32'h0000_0011);
    hold = 1'b1; rd_addr_a = 5'd2;
    tick();
    check_eq("hold_frozen", rd_data_a, 32'h0000_0011);
    wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h0000_0088;
    issue_en = 1'b1; issue_addr = 5'd10;
    tick();
    wb_en = 1'b0; issue_en = 1'b0;
    check_eq("hold_frozen2", rd_data_a, 32'h0000_0011);
    hold = 1'b0;
    tick();
    check_eq("hold_release", rd_data_a, 32'h0000_0022);
    rd_addr_a = 5'd8; rd_addr_b = 5'd10;
    tick();
    check_eq("write_during_hold", rd_data_a, 32'h0000_0088);
    check_eq("issue_during_hold", 32'(busy_b), 32'h1);

    // Asynchronous reset mid-operation
    write_reg(5'd9, 32'hA5A5_A5A5);
    issue_en = 1'b1; issue_addr = 5'd9;
    tick();
    issue_en = 1'b0; rd_addr_a = 5'd9;
    tick();
    check_eq("pre_rst_reg9", rd_data_a, 32'hA5A5_A5A5);
    check_eq("pre_rst_busy9", 32'(busy_a), 32'h1);
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h0BAD_0BAD;
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_rd_a", rd_data_a, 32'h0);
    check_eq("async_rst_busy_a", 32'(busy_a), 32'h0);
    check_eq("async_rst_busy_b", 32'(busy_b), 32'h0);
    wb_en = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_reg9", rd_data_a, 32'h0);
    check_eq("post_rst_busy9", 32'(busy_a), 32'h0);
    rd_addr_a = 5'd5;
    tick();
    check_eq("post_rst_reg5", rd_data_a, 32'h0);
    write_reg(5'd5, 32'h5555_AAAA);
    tick();
    check_eq("post_rst_write", rd_data_a, 32'h5555_AAAA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
